regfile_mp: RTL and testbench

Parametrised multi-port register file for the integer and FPU datapaths. It provides NRD combinational read ports and two synchronous write ports: port 0 for single-cycle ALU results and port 1 for long-latency FPU/load results. It also holds a per-register pending-write scoreboard that the issue stage uses to stall on RAW hazards. It sits between decode (read and issue) and writeback.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_rdport.sv | 43 ++++
 rtl/regfile_mp.sv | 80 ++++++++
 tb/tb_regfile_mp.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and port slicing helpers for regfile_mp.
// Holds the default widths of the integer and FP register files, and the
// offset helpers that locate read port i inside the packed rn and q buses.
package regfile_pkg;
    localparam int INT_DATA_W = 32;
    localparam int INT_ADDR_W = 5;
    localparam int FP_DATA_W  = 32;
    localparam int FP_ADDR_W  = 5;

    function automatic int rn_lo(input int i, input int addr_w);
        return i * addr_w;
    endfunction

    function automatic int q_lo(input int i, input int data_w);
        return i * data_w;
    endfunction
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port of regfile_mp.
// Ports: rn (register number), rdata/rbusy_raw (array word and busy bit
// already selected by rn), write/issue inputs (only with REGFILE_BYPASS_EN),
// q (read data), rbusy (pending-write flag).
// Macro REGFILE_BYPASS_EN adds the write-through bypass; the default build
// reads the array only.
module regfile_rdport import regfile_pkg::*; #(
    parameter int DATA_W   = INT_DATA_W,
    parameter int ADDR_W   = INT_ADDR_W,
    parameter int HAS_ZERO = 1
) (
    input  logic [ADDR_W-1:0] rn,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rbusy_raw,
`ifdef REGFILE_BYPASS_EN
    input  logic              we0,
    input  logic [ADDR_W-1:0] wn0,
    input  logic [DATA_W-1:0] d0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wn1,
    input  logic [DATA_W-1:0] d1,
    input  logic              bset,
    input  logic [ADDR_W-1:0] bsn,
`endif
    output logic [DATA_W-1:0] q,
    output logic              rbusy
);
    logic zero;
    assign zero = (HAS_ZERO != 0) && (rn == '0);
`ifdef REGFILE_BYPASS_EN
    logic hit0, hit1, set;
    assign hit0  = we0 && (wn0 == rn);
    assign hit1  = we1 && (wn1 == rn);
    assign set   = bset && (bsn == rn);
    // Port 1 has priority, matching the collision rule of the array write.
    assign q     = zero ? '0 : hit1 ? d1 : hit0 ? d0 : rdata;
    // A completing long-latency write clears the hazard unless a new producer is issued on the same edge.
    assign rbusy = rbusy_raw && !(hit1 && !set);
`else
    assign q     = zero ? '0 : rdata;
    assign rbusy = rbusy_raw;
`endif
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with pending-write scoreboard.
// Ports: clk, clrn (async active-low reset), rn/q/rbusy (NRD read ports),
// we0/wn0/d0 (ALU write), we1/wn1/d1 (long-latency write, clears busy),
// bset/bsn (mark destination pending), busy (raw scoreboard).
// Macro REGFILE_BYPASS_EN enables write-through bypass in the read ports.
module regfile_mp import regfile_pkg::*; #(
    parameter int DATA_W   = INT_DATA_W,
    parameter int ADDR_W   = INT_ADDR_W,
    parameter int NRD      = 3,
    parameter int HAS_ZERO = 1
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic [NRD*ADDR_W-1:0]   rn,
    output logic [NRD*DATA_W-1:0]   q,
    output logic [NRD-1:0]          rbusy,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       wn0,
    input  logic [DATA_W-1:0]       d0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       wn1,
    input  logic [DATA_W-1:0]       d1,
    input  logic                    bset,
    input  logic [ADDR_W-1:0]       bsn,
    output logic [2**ADDR_W-1:0]    busy
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              w0, w1, s;

    assign w0 = we0 && !((HAS_ZERO != 0) && (wn0 == '0));
    assign w1 = we1 && !((HAS_ZERO != 0) && (wn1 == '0));
    assign s  = bset && !((HAS_ZERO != 0) && (bsn == '0));

    // Set is applied after clear so a same-edge issue to the completing register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (we1) busy_d[wn1] = 1'b0;
        if (s) busy_d[bsn] = 1'b1;
    end

    // Port 1 is written last so it wins a same-register collision.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            busy_q <= '0;
        end else begin
            if (w0) mem_q[wn0] <= d0;
            if (w1) mem_q[wn1] <= d1;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] r;
        assign r = rn[rn_lo(i, ADDR_W) +: ADDR_W];
        regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HAS_ZERO(HAS_ZERO)) u_rd (
            .rn(r),
            .rdata(mem_q[r]),
            .rbusy_raw(busy_q[r]),
`ifdef REGFILE_BYPASS_EN
            // Bypass is gated by reset so outputs read zero while clrn is low.
            .we0(we0 && clrn),
            .wn0(wn0),
            .d0(d0),
            .we1(we1 && clrn),
            .wn1(wn1),
            .d1(d1),
            .bset(bset),
            .bsn(bsn),
`endif
            .q(q[q_lo(i, DATA_W) +: DATA_W]),
            .rbusy(rbusy[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of an integer (HAS_ZERO=1) and an FP (HAS_ZERO=0) regfile_mp.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        clrn = 1'b1;
    logic [4:0]  ra [3];
    logic [14:0] rn;
    logic        we0, we1, bset;
    logic [4:0]  wn0, wn1, bsn;
    logic [31:0] d0, d1;
    logic [95:0] qi, qf;
    logic [2:0]  rbi, rbf;
    logic [31:0] bi, bf;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_reg  [2][32];
    logic [31:0] m_busy [2];

    assign rn = {ra[2], ra[1], ra[0]};

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(3), .HAS_ZERO(1)) dut_i (
        .clk(clk), .clrn(clrn), .rn(rn), .q(qi), .rbusy(rbi),
        .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
        .bset(bset), .bsn(bsn), .busy(bi)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(3), .HAS_ZERO(0)) dut_f (
        .clk(clk), .clrn(clrn), .rn(rn), .q(qf), .rbusy(rbf),
        .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
        .bset(bset), .bsn(bsn), .busy(bf)
    );

    // Reference: file 0 is the integer file (r0 hardwired), file 1 the FP file.
    always @(posedge clk or negedge clrn) begin
        for (int f = 0; f < 2; f++) begin
            if (!clrn) begin
                for (int r = 0; r < 32; r++) m_reg[f][r] = '0;
                m_busy[f] = '0;
            end else begin
                if (we0 && !(f == 0 && wn0 == 0)) m_reg[f][wn0] = d0;
                if (we1 && !(f == 0 && wn1 == 0)) m_reg[f][wn1] = d1;
                if (we1) m_busy[f][wn1] = 1'b0;
                if (bset && !(f == 0 && bsn == 0)) m_busy[f][bsn] = 1'b1;
            end
        end
    end

    function automatic logic [31:0] exp_q(input int f, input logic [4:0] r);
        if (!clrn || (f == 0 && r == 0)) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we1 && wn1 == r) return d1;
        if (we0 && wn0 == r) return d0;
`endif
        return m_reg[f][r];
    endfunction

    function automatic logic exp_rb(input int f, input logic [4:0] r);
        if (!clrn) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we1 && wn1 == r && !(bset && bsn == r)) return 1'b0;
`endif
        return m_busy[f][r];
    endfunction

    always @(negedge clk) begin : cmp
        logic [31:0] aq, eq, ab, eb;
        logic        ar, er;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) begin
                aq = (f == 0) ? qi[i*32 +: 32] : qf[i*32 +: 32];
                eq = exp_q(f, ra[i]);
                checks++;
                if (aq !== eq) begin
                    errors++;
                    $display("FAIL q f%0d p%0d r%0d got %h want %h t=%0t", f, i, ra[i], aq, eq, $time);
                end
                ar = (f == 0) ? rbi[i] : rbf[i];
                er = exp_rb(f, ra[i]);
                checks++;
                if (ar !== er) begin
                    errors++;
                    $display("FAIL rbusy f%0d p%0d r%0d got %b want %b t=%0t", f, i, ra[i], ar, er, $time);
                end
            end
            ab = (f == 0) ? bi : bf;
            eb = m_busy[f];
            checks++;
            if (ab !== eb) begin
                errors++;
                $display("FAIL busy f%0d got %h want %h t=%0t", f, ab, eb, $time);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; bset = 0; wn0 = 0; wn1 = 0; bsn = 0; d0 = 0; d1 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick();
        return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        idle();
        ra[0] = 5; ra[1] = 0; ra[2] = 0;
        #1 clrn = 1'b0;
        #2;
        chk("reset_q_i", qi[31:0], 32'h0);
        chk("reset_busy_i", bi, 32'h0);
        chk("reset_busy_f", bf, 32'h0);
        #9 clrn = 1'b1;
        tick();
        we0 = 1; wn0 = 5; d0 = 32'hDEADBEEF; bset = 1; bsn = 5;
        tick();
        idle();
        @(negedge clk);
        chk("wr_r5_i", qi[31:0], 32'hDEADBEEF);
        chk("wr_r5_busy_f", bf, 32'h0000_0020);
        #2 clrn = 1'b0;
        #1;
        chk("midrst_q_i", qi[31:0], 32'h0);
        chk("midrst_q_f", qf[31:0], 32'h0);
        chk("midrst_busy_i", bi, 32'h0);
        #1 clrn = 1'b1;
        tick();
        we0 = 1; we1 = 1; wn0 = 7; wn1 = 7; d0 = 32'h11; d1 = 32'h22;
        tick();
        idle();
        ra[0] = 7;
        @(negedge clk);
        chk("collide_i", qi[31:0], 32'h22);
        chk("collide_f", qf[31:0], 32'h22);
        tick();
        we0 = 1; wn0 = 0; d0 = 32'h1234;
        tick();
        idle();
        bset = 1; bsn = 0;
        tick();
        idle();
        ra[0] = 0;
        @(negedge clk);
        chk("zero_q_i", qi[31:0], 32'h0);
        chk("zero_busy0_i", {31'b0, bi[0]}, 32'h0);
        chk("zero_q_f", qf[31:0], 32'h1234);
        chk("zero_busy0_f", {31'b0, bf[0]}, 32'h1);
        tick();
        bset = 1; bsn = 9;
        tick();
        idle();
        ra[1] = 9;
        @(negedge clk);
        chk("sb_set_rbusy_i", {31'b0, rbi[1]}, 32'h1);
        tick();
        we1 = 1; wn1 = 9; d1 = 32'h3F800000;
        tick();
        idle();
        @(negedge clk);
        chk("sb_clr_busy9_i", {31'b0, bi[9]}, 32'h0);
        chk("sb_clr_q_i", qi[63:32], 32'h3F800000);
        tick();
        bset = 1; bsn = 9; we1 = 1; wn1 = 9; d1 = 32'h40000000;
        tick();
        idle();
        @(negedge clk);
        chk("sb_setwins_i", {31'b0, bi[9]}, 32'h1);
        chk("sb_setwins_q_i", qi[63:32], 32'h40000000);
        tick();
        we0 = 1; wn0 = 4; d0 = 32'h5555; bset = 1; bsn = 4;
        ra[2] = 4;
        tick();
        idle();
        we1 = 1; wn1 = 4; d1 = 32'hA5A5A5A5;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("byp_q2_i", qi[95:64], 32'hA5A5A5A5);
        chk("byp_rbusy2_i", {31'b0, rbi[2]}, 32'h0);
`else
        chk("nobyp_q2_i", qi[95:64], 32'h5555);
        chk("nobyp_rbusy2_i", {31'b0, rbi[2]}, 32'h1);
`endif
        tick();
        idle();
        @(negedge clk);
        chk("after_q2_i", qi[95:64], 32'hA5A5A5A5);
        chk("after_rbusy2_i", {31'b0, rbi[2]}, 32'h0);
        for (int c = 0; c < 10000; c++) begin
            tick();
            we0 = 1'($urandom); wn0 = pick(); d0 = $urandom;
            we1 = 1'($urandom); wn1 = pick(); d1 = $urandom;
            bset = ($urandom_range(0, 2) == 0); bsn = pick();
            for (int i = 0; i < 3; i++) ra[i] = pick();
            if ($urandom_range(0, 999) == 0) begin
                #1 clrn = 1'b0;
                #1 clrn = 1'b1;
            end
        end
        tick();
        idle();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
